alu_mul_sequencer: RTL

- Multi-cycle 32x32 -> 64-bit multiply controller for the SPARC integer unit.
- Has no adder of its own. It borrows the shared 32-bit ALU through a request/grant pair and issues one add-with-S step per granted cycle, shift-and-add style.
- Delivers the 64-bit product: high word to Y, low word to rd. Also delivers the integer condition codes (icc) for UMUL/SMUL.

---
 rtl/alu_mul_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32->64 multiply sequencer that borrows the shared ALU one step per grant.
// Optional signed (SMUL) support is enabled by defining ALU_MUL_SIGNED_EN.
module alu_mul_sequencer #(
   parameter int WIDTH      = 32,
   parameter int STEP_CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef ALU_MUL_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] mplier,
   input  logic [WIDTH-1:0] mcand,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_n,
   input  logic             alu_v,
   input  logic             alu_c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic             icc_n,
   output logic             icc_z,
   output logic             icc_v,
   output logic             icc_c
);

   localparam logic [5:0] OP_ADDCC = 6'b010000;
   localparam logic [5:0] OP_SUBCC = 6'b010100;
   localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [STEP_CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0]      hi_q, lo_q, mc_q;
   logic                  busy_d, req_d, done_d;
   logic                  run, step, last_step, sub_step, shift_in;

   assign run       = (state_q == RUN);
   assign step      = run && alu_gnt;
   assign last_step = (cnt_q == LAST_STEP);

`ifdef ALU_MUL_SIGNED_EN
   logic signed_q;
   // The multiplier MSB carries negative weight, so the final partial product is subtracted.
   assign sub_step = signed_q && last_step;
   assign shift_in = signed_q ? (alu_n ^ alu_v) : alu_c;
`else
   logic unused_flags;
   assign unused_flags = alu_n ^ alu_v;
   assign sub_step     = 1'b0;
   assign shift_in     = alu_c;
`endif

   assign alu_a      = run ? hi_q : '0;
   assign alu_b      = (run && lo_q[0]) ? mc_q : '0;
   assign alu_opcode = run ? (sub_step ? OP_SUBCC : OP_ADDCC) : 6'b000000;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (step && last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      req_d  = (state_d == RUN);
      done_d = (state_q == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         alu_req <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         alu_req <= req_d;
         done    <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mc_q     <= '0;
`ifdef ALU_MUL_SIGNED_EN
         signed_q <= 1'b0;
`endif
      end else if (state_q == IDLE && start) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= mplier;
         mc_q     <= mcand;
`ifdef ALU_MUL_SIGNED_EN
         signed_q <= signed_op;
`endif
      end else if (step) begin
         {hi_q, lo_q} <= {shift_in, alu_result, lo_q[WIDTH-1:1]};
         cnt_q        <= cnt_q + 1'b1;
      end
   end

   // Product and condition codes are captured only when a multiply completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_hi <= '0;
         prod_lo <= '0;
         icc_n   <= 1'b0;
         icc_z   <= 1'b0;
      end else if (state_q == DONE) begin
         prod_hi <= hi_q;
         prod_lo <= lo_q;
         icc_n   <= lo_q[WIDTH-1];
         icc_z   <= (lo_q == '0);
      end
   end

   assign icc_v = 1'b0;
   assign icc_c = 1'b0;

endmodule
